// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// default burst/tenure parameters, counter widths and a saturating increment.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_ACC  = 3'd1,
    ST_PEND     = 3'd2,
    ST_DMA_OWN  = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_e;

  localparam logic [2:0] NUM_DATA_CPU        = 3'b001;
  localparam int         DEFAULT_BURST_WORDS = 4;
  localparam int         DEFAULT_MAX_HOLD    = 32;
  localparam int         CNT_W               = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_tenure.sv
// -----------------------------------------------------------------------------
// dma_tenure_timer
// Tracks how long the DMA has held the bus in the current grant.
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : first edge of a new grant; zeroes both counters
//   active       : bus currently owned by the DMA
//   mem_ready    : memory transaction complete (one burst done)
//   burst_count  : bursts finished in the current grant, saturating
//   preempt_ok   : tenure has reached MAX_HOLD cycles
// Both counters keep their value after the grant ends so burst_count stays
// readable until the next grant starts.
// -----------------------------------------------------------------------------
module dma_tenure_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] burst_count,
  output logic             preempt_ok
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      burst_count <= '0;
    end else if (clear) begin
      hold_cnt    <= '0;
      burst_count <= '0;
    end else if (active) begin
      hold_cnt <= sat_inc(hold_cnt);
      if (mem_ready) burst_count <= sat_inc(burst_count);
    end
  end

  assign preempt_ok = (hold_cnt >= HOLD_LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates memory port 2 between the CPU data path and the DMA controller.
//   clk, reset              : clock, asynchronous active-high reset
//   cpu_read_req/write_req  : CPU data request, held until serviced
//   cpu_addr, dma_addr      : candidate addresses for the memory port
//   br                      : DMA bus request (level)
//   mem_ready               : one-cycle pulse, current transaction complete
//   bg                      : bus grant to the DMA side
//   cpu_stall               : CPU must freeze (combinational)
//   mem_read, mem_write     : memory port strobes
//   mem_addr, num_data      : memory port address and transaction length
//   burst_count             : DMA bursts completed in current grant (debug)
// All outputs except cpu_stall are registered decodes of the next state, so
// they change on the same edge as the state they describe.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BURST_WORDS = DEFAULT_BURST_WORDS,
  parameter int MAX_HOLD    = DEFAULT_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_read_req,
  input  logic                 cpu_write_req,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic                 br,
  input  logic                 mem_ready,
  output logic                 bg,
  output logic                 cpu_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [2:0]           num_data,
  output logic [CNT_W-1:0]     burst_count
);

  localparam logic [2:0] NUM_DATA_DMA = 3'(BURST_WORDS);

  arb_state_e state, next_state;
  logic       cpu_prio;
  logic       cpu_req;
  logic       preempt_ok;
  logic       preempt;
  logic       enter_dma;

  assign cpu_req = cpu_read_req | cpu_write_req;

  // Preemption only at a burst boundary, and only once tenure is exhausted.
  assign preempt = (state == ST_DMA_OWN) && br && mem_ready && preempt_ok && cpu_req;

  // NOTE: next_state gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (br && !(cpu_prio && cpu_req)) next_state = ST_DMA_OWN;
        else if (cpu_req)                 next_state = ST_CPU_ACC;
      end
      ST_CPU_ACC: begin
        // An in-flight CPU access always completes, even if br rises.
        if (mem_ready) next_state = br ? ST_DMA_OWN : ST_IDLE;
      end
      ST_PEND:    next_state = ST_CPU_ACC;
      ST_DMA_OWN: begin
        if (!br)          next_state = ST_RELEASE;
        else if (preempt) next_state = ST_PEND;
      end
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  assign enter_dma = (next_state == ST_DMA_OWN) && (state != ST_DMA_OWN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_prio  <= 1'b0;
      bg        <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      num_data  <= NUM_DATA_CPU;
    end else begin
      state <= next_state;

      if (preempt)                                cpu_prio <= 1'b1;
      else if (state == ST_CPU_ACC && mem_ready)  cpu_prio <= 1'b0;

      // Bus idle unless the next state owns it; address/length hold.
      bg        <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (next_state)
        ST_CPU_ACC: begin
          // Read wins if both are raised, so the strobes are never both high.
          mem_read  <= cpu_read_req;
          mem_write <= cpu_write_req & ~cpu_read_req;
          mem_addr  <= cpu_addr;
          num_data  <= NUM_DATA_CPU;
        end
        ST_DMA_OWN: begin
          bg        <= 1'b1;
          mem_write <= 1'b1;
          mem_addr  <= dma_addr;
          num_data  <= NUM_DATA_DMA;
        end
        default: ;
      endcase
    end
  end

  // Released in the completing cycle so the CPU advances on the same edge the
  // access retires; gated by reset so the CPU is never held during reset.
  assign cpu_stall = !reset && cpu_req && !((state == ST_CPU_ACC) && mem_ready);

  dma_tenure_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_tenure (
    .clk         (clk),
    .reset       (reset),
    .clear       (enter_dma),
    .active      (state == ST_DMA_OWN),
    .mem_ready   (mem_ready),
    .burst_count (burst_count),
    .preempt_ok  (preempt_ok)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed stimulus pushes expected output values, tagged with the cycle they
// must appear in, onto a scoreboard queue; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int WS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read_req, cpu_write_req;
  logic [WS-1:0] cpu_addr, dma_addr;
  logic          br, mem_ready;
  logic          bg, cpu_stall, mem_read, mem_write;
  logic [WS-1:0] mem_addr;
  logic [2:0]    num_data;
  logic [7:0]    burst_count;

  typedef enum {SIG_BG, SIG_STALL, SIG_RD, SIG_WR, SIG_ADDR, SIG_NUM, SIG_BC} sig_e;
  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_bus_arbiter #(
    .WORD_SIZE   (WS),
    .BURST_WORDS (4),
    .MAX_HOLD    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_read_req  (cpu_read_req),
    .cpu_write_req (cpu_write_req),
    .cpu_addr      (cpu_addr),
    .dma_addr      (dma_addr),
    .br            (br),
    .mem_ready     (mem_ready),
    .bg            (bg),
    .cpu_stall     (cpu_stall),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .num_data      (num_data),
    .burst_count   (burst_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] sample(input sig_e s);
    case (s)
      SIG_BG:    return {15'd0, bg};
      SIG_STALL: return {15'd0, cpu_stall};
      SIG_RD:    return {15'd0, mem_read};
      SIG_WR:    return {15'd0, mem_write};
      SIG_ADDR:  return mem_addr;
      SIG_NUM:   return {13'd0, num_data};
      default:   return {8'd0, burst_count};
    endcase
  endfunction

  // Monitor: outputs are compared mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc == cyc) begin
        check(cur.sig.name(), sample(cur.sig), cur.val);
      end else begin
        n_checks++;
        n_errors++;
        $display("FAIL stale_%s: expectation for cyc %0d missed, now %0d", cur.sig.name(), cur.cyc, cyc);
      end
    end
  end

  task automatic exp_at(input sig_e s, input logic [15:0] v);
    sb.push_back('{cyc, s, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_read_req = 1'b0; cpu_write_req = 1'b0;
    cpu_addr = '0; dma_addr = '0; br = 1'b0; mem_ready = 1'b0;

    // Reset values; stall must stay low while reset is high even with a request.
    tick(); tick();
    cpu_read_req = 1'b1;
    exp_at(SIG_STALL, 16'd0); exp_at(SIG_BG, 16'd0); exp_at(SIG_RD, 16'd0);
    exp_at(SIG_WR, 16'd0);    exp_at(SIG_ADDR, 16'h0); exp_at(SIG_NUM, 16'd1);
    exp_at(SIG_BC, 16'd0);
    tick();
    cpu_read_req = 1'b0; reset = 1'b0;
    tick();

    // CPU read of 0x0040, mem_ready two cycles after the strobe starts.
    cpu_read_req = 1'b1; cpu_addr = 16'h0040;
    exp_at(SIG_STALL, 16'd1);
    tick();
    exp_at(SIG_RD, 16'd1); exp_at(SIG_WR, 16'd0); exp_at(SIG_ADDR, 16'h0040);
    exp_at(SIG_NUM, 16'd1); exp_at(SIG_BG, 16'd0); exp_at(SIG_STALL, 16'd1);
    tick();
    mem_ready = 1'b1;
    exp_at(SIG_RD, 16'd1); exp_at(SIG_STALL, 16'd0);
    tick();
    mem_ready = 1'b0; cpu_read_req = 1'b0;
    exp_at(SIG_RD, 16'd0); exp_at(SIG_STALL, 16'd0); exp_at(SIG_BG, 16'd0);
    tick();

    // br rises mid CPU write: write completes, then grant.
    cpu_write_req = 1'b1; cpu_addr = 16'h0123; dma_addr = 16'h8000;
    tick();
    exp_at(SIG_WR, 16'd1); exp_at(SIG_RD, 16'd0); exp_at(SIG_ADDR, 16'h0123);
    br = 1'b1;
    exp_at(SIG_BG, 16'd0);
    tick();
    exp_at(SIG_WR, 16'd1); exp_at(SIG_BG, 16'd0); exp_at(SIG_ADDR, 16'h0123);
    mem_ready = 1'b1;
    exp_at(SIG_STALL, 16'd0);
    tick();
    mem_ready = 1'b0; cpu_write_req = 1'b0;
    exp_at(SIG_BG, 16'd1); exp_at(SIG_WR, 16'd1); exp_at(SIG_RD, 16'd0);
    exp_at(SIG_ADDR, 16'h8000); exp_at(SIG_NUM, 16'd4); exp_at(SIG_BC, 16'd0);

    // Three DMA bursts, then release with exactly one turnaround cycle.
    for (int i = 1; i <= 3; i++) begin
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      exp_at(SIG_BC, 16'(i)); exp_at(SIG_BG, 16'd1);
    end
    br = 1'b0;
    tick();
    exp_at(SIG_BG, 16'd0); exp_at(SIG_WR, 16'd0); exp_at(SIG_BC, 16'd3);
    cpu_read_req = 1'b1; cpu_addr = 16'h0200;
    tick();
    exp_at(SIG_RD, 16'd0); exp_at(SIG_BG, 16'd0); exp_at(SIG_STALL, 16'd1);
    exp_at(SIG_BC, 16'd3);
    tick();
    exp_at(SIG_RD, 16'd1); exp_at(SIG_ADDR, 16'h0200);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; cpu_read_req = 1'b0;
    exp_at(SIG_RD, 16'd0);
    tick();

    // Preemption with MAX_HOLD=8: early burst keeps the grant, the burst
    // ending at hold_cnt=8 hands the port to the pending CPU read.
    br = 1'b1; dma_addr = 16'h9000;
    tick();
    cpu_read_req = 1'b1; cpu_addr = 16'h0300;
    exp_at(SIG_BG, 16'd1); exp_at(SIG_STALL, 16'd1); exp_at(SIG_ADDR, 16'h9000);
    repeat (4) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    exp_at(SIG_BC, 16'd1); exp_at(SIG_BG, 16'd1);
    repeat (3) tick();
    mem_ready = 1'b1;
    exp_at(SIG_BG, 16'd1);
    tick();
    mem_ready = 1'b0;
    exp_at(SIG_BG, 16'd0); exp_at(SIG_RD, 16'd0); exp_at(SIG_WR, 16'd0);
    exp_at(SIG_STALL, 16'd1); exp_at(SIG_BC, 16'd2);
    tick();
    exp_at(SIG_RD, 16'd1); exp_at(SIG_ADDR, 16'h0300); exp_at(SIG_NUM, 16'd1);
    exp_at(SIG_BG, 16'd0);
    mem_ready = 1'b1;
    exp_at(SIG_STALL, 16'd0);
    tick();
    mem_ready = 1'b0; cpu_read_req = 1'b0;
    exp_at(SIG_BG, 16'd1); exp_at(SIG_WR, 16'd1); exp_at(SIG_BC, 16'd0);
    exp_at(SIG_ADDR, 16'h9000); exp_at(SIG_NUM, 16'd4);
    br = 1'b0;
    tick(); tick();

    // br and CPU write on the same edge from IDLE: DMA first.
    br = 1'b1; cpu_write_req = 1'b1; cpu_addr = 16'h0400; dma_addr = 16'hA000;
    exp_at(SIG_STALL, 16'd1);
    tick();
    exp_at(SIG_BG, 16'd1); exp_at(SIG_WR, 16'd1); exp_at(SIG_RD, 16'd0);
    exp_at(SIG_ADDR, 16'hA000); exp_at(SIG_STALL, 16'd1);
    tick();
    br = 1'b0;
    exp_at(SIG_STALL, 16'd1); exp_at(SIG_BG, 16'd1);
    tick();
    exp_at(SIG_BG, 16'd0); exp_at(SIG_WR, 16'd0); exp_at(SIG_STALL, 16'd1);
    tick();
    exp_at(SIG_BG, 16'd0); exp_at(SIG_WR, 16'd0); exp_at(SIG_STALL, 16'd1);
    tick();
    exp_at(SIG_WR, 16'd1); exp_at(SIG_ADDR, 16'h0400); exp_at(SIG_NUM, 16'd1);
    mem_ready = 1'b1;
    exp_at(SIG_STALL, 16'd0);
    tick();
    mem_ready = 1'b0; cpu_write_req = 1'b0;
    exp_at(SIG_WR, 16'd0);
    tick();

    // Asynchronous reset in the middle of a grant.
    br = 1'b1; dma_addr = 16'hB000;
    tick();
    mem_ready = 1'b1;
    exp_at(SIG_BG, 16'd1);
    tick();
    mem_ready = 1'b0;
    exp_at(SIG_BC, 16'd1); exp_at(SIG_BG, 16'd1); exp_at(SIG_WR, 16'd1);
    tick();
    #1 reset = 1'b1;
    exp_at(SIG_BG, 16'd0); exp_at(SIG_WR, 16'd0); exp_at(SIG_BC, 16'd0);
    exp_at(SIG_ADDR, 16'h0); exp_at(SIG_NUM, 16'd1); exp_at(SIG_STALL, 16'd0);
    tick();
    reset = 1'b0; br = 1'b0; cpu_read_req = 1'b1; cpu_addr = 16'h0500;
    exp_at(SIG_STALL, 16'd1); exp_at(SIG_BG, 16'd0);
    tick();
    exp_at(SIG_RD, 16'd1); exp_at(SIG_ADDR, 16'h0500); exp_at(SIG_BG, 16'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; cpu_read_req = 1'b0;
    exp_at(SIG_RD, 16'd0);
    tick(); tick();

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequencer and arbiter for the shared data-memory port (memory port 2) between the CPU data path and the DMA controller. Owns the BR/BG handshake, drives the memory port's read/write strobes, address mux and burst length, and stalls the CPU while the DMA holds the bus. Bounds DMA bus tenure so CPU data accesses are never starved. Sits between `cpu`, `DMA_controller` and `Memory` in the top level.

## Interface
- WORD_SIZE, 16, address/data word width
- BURST_WORDS, 4, words per DMA memory transaction (driven on num_data)
- MAX_HOLD, 32, cycles of DMA tenure after which a pending CPU request preempts at the next burst boundary
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- cpu_read_req  in  1  CPU data read request, held until serviced
- cpu_write_req  in  1  CPU data write request, held until serviced
- cpu_addr  in  WORD_SIZE  CPU data address
- dma_addr  in  WORD_SIZE  DMA target address (address_to_mem)
- br  in  1  DMA bus request, level, held for whole transfer
- mem_ready  in  1  one-cycle pulse: current memory transaction complete
- bg  out  1  bus grant to DMA controller and external device
- cpu_stall  out  1  CPU must hold its request and freeze
- mem_read  out  1  memory port read strobe
- mem_write  out  1  memory port write strobe
- mem_addr  out  WORD_SIZE  memory port address
- num_data  out  3  words in current transaction (1 for CPU, BURST_WORDS for DMA)
- burst_count  out  8  DMA bursts completed in current grant (debug)

## Operation
- States: IDLE, CPU_ACC, PEND, DMA_OWN, RELEASE.
- IDLE: br=1 and cpu_prio=0 -> DMA_OWN; else cpu_read_req|cpu_write_req -> CPU_ACC; else stay. br=1 with cpu_prio=1 and CPU request -> CPU_ACC.
- CPU_ACC: mem_read/mem_write mirror the CPU request, mem_addr=cpu_addr, num_data=1. On mem_ready: clear cpu_prio; br=1 -> DMA_OWN, else IDLE. br arriving mid-access never aborts it.
- PEND: entered from DMA_OWN on preemption; one cycle with bg=0, no strobes, then CPU_ACC.
- DMA_OWN: bg=1, mem_write=1, mem_addr=dma_addr, num_data=BURST_WORDS. Each mem_ready increments burst_count (saturates at 255). hold_cnt increments every cycle.
  - br falls -> RELEASE.
  - mem_ready with hold_cnt>=MAX_HOLD and CPU request pending -> set cpu_prio, PEND.
- RELEASE: one turnaround cycle, bg=0, no strobes; then IDLE. burst_count and hold_cnt clear on entry to DMA_OWN only (burst_count remains readable after release).
- cpu_stall = CPU request pending and not (state==CPU_ACC and mem_ready).
- Never both strobes high; never CPU strobes while bg=1.

## Timing
- All outputs except cpu_stall are registered decodes of state; cpu_stall is combinational.
- Reset values: state IDLE, bg 0, mem_read 0, mem_write 0, mem_addr 0, num_data 3'b001, burst_count 0, hold_cnt 0, cpu_prio 0; cpu_stall 0 while reset is high.
- CPU latency: request seen at edge N (state IDLE) -> strobes from N+1 -> stall drops in the mem_ready cycle.
- Grant latency: br at edge N in IDLE -> bg high from N+1; br during CPU_ACC -> bg one cycle after that access's mem_ready.
- Release: br low at edge N -> bg low from N+1, IDLE at N+2.
- Simultaneous br and CPU request in IDLE: DMA wins unless cpu_prio.
- Reset mid-grant: bg drops asynchronously; the DMA controller must restart.

## Structure
- Shared package: state enum encoding, NUM_DATA_CPU = 3'b001, default BURST_WORDS/MAX_HOLD.
- One sub-module natural: `dma_tenure_timer` (hold_cnt, burst_count, saturation, preempt-eligible flag).

## Test plan
- CPU read 0x0040 alone, mem_ready 2 cycles later -> mem_read 1 for 2 cycles, num_data=1, stall low in mem_ready cycle, back to IDLE.
- br rises during CPU write -> write completes, bg=1 cycle after mem_ready, mem_addr=dma_addr, num_data=4.
- DMA 3 bursts then br low -> burst_count=3, bg low next cycle, one RELEASE cycle, then IDLE.
- MAX_HOLD=8, br held, CPU read pending -> at first mem_ready with hold_cnt>=8: PEND, CPU_ACC, then DMA_OWN with burst_count=0.
- br and CPU request same edge from IDLE (cpu_prio=0) -> DMA granted first, CPU stalled until RELEASE.
- reset asserted in DMA_OWN -> bg, mem_write, burst_count 0 immediately; state IDLE.
